// File: rtl/axi4lite_apb_bridge_pkg.sv
// axi4lite_apb_bridge_pkg: shared state encoding, response codes and bus widths
package axi_apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
endpackage

// File: rtl/axi4lite_apb_bridge_if.sv
// axi4lite_apb_bridge_if: AXI4-Lite slave side and APB master side of the bridge
interface axi4lite_apb_bridge_if;
  import axi_apb_pkg::*;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [APB_ADDR_W-1:0] awaddr, araddr, paddr;
  logic [2:0] awprot, arprot, pprot;
  logic [APB_DATA_W-1:0] wdata, rdata, pwdata, prdata;
  logic [3:0] wstrb, pstrb;
  logic [1:0] bresp, rresp;
  logic psel, penable, pwrite, pready, pslverr;
  modport slave (
    input awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input pready, prdata, pslverr,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    output paddr, psel, penable, pprot, pwrite, pwdata, pstrb
  );
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output pready, prdata, pslverr,
    input awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
    input paddr, psel, penable, pprot, pwrite, pwdata, pstrb
  );
endinterface

// File: rtl/axi4lite_apb_bridge.sv
// axi4lite_apb_bridge: single-outstanding AXI4-Lite to APB bridge with round-robin
// read/write arbitration and an ACCESS-phase watchdog
module axi4lite_apb_bridge
  import axi_apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clock,
  input logic reset,
  axi4lite_apb_bridge_if.slave bus
);
  localparam logic [15:0] TIMEOUT = 16'(TIMEOUT_CYCLES);
  state_t state, state_n;
  logic last_w, write;
  logic [APB_ADDR_W-1:0] addr;
  logic [APB_DATA_W-1:0] data, rdata;
  logic [3:0] strb;
  logic [2:0] prot;
  logic [1:0] resp;
  logic [15:0] wdog;
  logic want_w, want_r, grant_w, grant_r, expire, done;
  // both candidates present: alternate away from whoever won last
  assign want_w = bus.awvalid && bus.wvalid;
  assign want_r = bus.arvalid;
  assign grant_w = state == IDLE && want_w && (!want_r || !last_w);
  assign grant_r = state == IDLE && want_r && !grant_w;
  assign expire = TIMEOUT != 16'd0 && wdog + 16'd1 == TIMEOUT;
  assign done = state == ACCESS && (bus.pready || expire);
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = grant_w || grant_r ? SETUP : IDLE;
      SETUP: state_n = ACCESS;
      ACCESS: state_n = done ? RESP : ACCESS;
      RESP: state_n = (write ? bus.bready : bus.rready) ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    bus.awready = grant_w;
    bus.wready = grant_w;
    bus.arready = grant_r;
    bus.psel = state == SETUP || state == ACCESS;
    bus.penable = state == ACCESS;
    bus.paddr = addr;
    bus.pprot = prot;
    bus.pwrite = write;
    bus.pwdata = data;
    bus.pstrb = strb;
    bus.bvalid = state == RESP && write;
    bus.rvalid = state == RESP && !write;
    bus.bresp = resp;
    bus.rresp = resp;
    bus.rdata = rdata;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      last_w <= 1'b0;
      write <= 1'b0;
      addr <= '0;
      prot <= '0;
      data <= '0;
      strb <= '0;
      rdata <= '0;
      resp <= RESP_OKAY;
      wdog <= '0;
    end else begin
      if (grant_w || grant_r) begin
        addr <= grant_w ? bus.awaddr : bus.araddr;
        prot <= grant_w ? bus.awprot : bus.arprot;
        data <= grant_w ? bus.wdata : '0;
        strb <= grant_w ? bus.wstrb : 4'h0;
        write <= grant_w;
        last_w <= grant_w;
      end
      // pready wins over a simultaneous watchdog expiry
      if (done) begin
        resp <= !bus.pready || bus.pslverr ? RESP_SLVERR : RESP_OKAY;
        if (!write) rdata <= bus.pready ? bus.prdata : '0;
      end
      if (state == SETUP) wdog <= '0;
      else if (state == ACCESS && !bus.pready) wdog <= wdog + 16'd1;
    end
  end
endmodule

// File: doc/axi4lite_apb_bridge.md
Name: axi4lite_apb_bridge

Overview:
Single-outstanding AXI4-Lite slave to APB master bridge; the APB side feeds the APB delay/timing stage and peripherals downstream.
Converts one AXI write (AW+W) or read (AR) into one APB SETUP/ACCESS transfer and returns B or R.
Arbitrates reads against writes round-robin.
Includes a watchdog so a hung APB slave cannot lock the CPU bus.

Parameters:
TIMEOUT_CYCLES, 1024, ACCESS-phase cycles without pready before forced error completion; 0 disables the watchdog

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
awvalid/awready  in/out  1/1  write address handshake
awaddr  in  32  write address
awprot  in  3  write protection
wvalid/wready  in/out  1/1  write data handshake
wdata  in  32  write data
wstrb  in  4  write byte strobes
bvalid/bready  out/in  1/1  write response handshake
bresp  out  2  write response (00 OKAY, 10 SLVERR)
arvalid/arready  in/out  1/1  read address handshake
araddr  in  32  read address
arprot  in  3  read protection
rvalid/rready  out/in  1/1  read data handshake
rdata  out  32  read data
rresp  out  2  read response
paddr  out  32  APB address
psel  out  1  APB select
penable  out  1  APB enable
pprot  out  3  APB protection
pwrite  out  1  APB direction
pwdata  out  32  APB write data
pstrb  out  4  APB strobes; 0 on reads
pready  in  1  APB ready
prdata  in  32  APB read data
pslverr  in  1  APB error

Behaviour:
- Reset state: IDLE. All valids, readys, psel and penable 0. Captured addr/data/strb/prot, rdata, bresp and rresp 0. last_grant = read.
- States: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE, write candidate: awvalid && wvalid both high. AW alone or W alone is never accepted.
- IDLE, read candidate: arvalid.
- IDLE arbitration: if both candidates are present, grant the opposite of last_grant.
- IDLE grant: drive the chosen readys high combinationally (awready and wready together, or arready). Latch addr/prot/data/strb/direction, update last_grant, go to SETUP next cycle.
- Outside IDLE, awready, wready and arready are 0. Only one transaction is outstanding.
- SETUP (1 cycle): psel=1, penable=0. paddr, pwrite, pwdata, pstrb and pprot are driven from the latches.
- ACCESS: psel=1, penable=1. APB outputs are held stable.
- ACCESS, on pready=1: capture prdata (reads only) and pslverr, then go to RESP. psel and penable are 0 in the following cycle.
- Watchdog: a 16-bit counter is cleared on entry to ACCESS and increments each ACCESS cycle with pready=0.
- Watchdog expiry: when the counter reaches TIMEOUT_CYCLES and TIMEOUT_CYCLES != 0, abandon the transfer (psel and penable drop) and go to RESP with response SLVERR and rdata=0.
- Watchdog vs pready: pready in the same cycle as expiry wins, and the real response is used.
- RESP: bvalid (write) or rvalid (read) is held with stable bresp/rresp/rdata until bready/rready is high. Exit to IDLE on the handshake cycle.
- Response encoding: pslverr=1 -> 2'b10, else 2'b00.
- Minimum latency, pready already high in ACCESS: AW/W or AR handshake at cycle 0, SETUP cycle 1, ACCESS cycle 2, bvalid/rvalid at cycle 3. Back-to-back throughput is 1 transfer per 4 cycles.
- Reset mid-transfer: next edge returns to IDLE and psel/penable/valids drop. No response is issued for the aborted transfer.

Decomposition:
- Package axi_apb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS, RESP};
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - APB_ADDR_W=32 and APB_DATA_W=32.
- Single module: no sub-module is needed. The watchdog stays inline (about 15 lines).

Test Plan:
- Write awaddr=0x1000_0004, wdata=0xA5A5_0001, wstrb=0xF, with pready tied 1 -> SETUP cycle 1, ACCESS cycle 2 with those values on paddr/pwdata/pstrb and pwrite=1, bvalid cycle 3, bresp=00.
- Read araddr=0x1000_0008, slave holds pready low 5 cycles then returns prdata=0x1234_5678 with pslverr=1 -> rvalid with rdata=0x1234_5678, rresp=10. APB outputs are stable through all 6 ACCESS cycles.
- AW+W and AR asserted together for 3 consecutive transactions after reset -> grant order write, read, write.
- awvalid without wvalid for 10 cycles -> awready stays 0 and no psel. When wvalid rises -> both readys pulse in the same cycle.
- TIMEOUT_CYCLES=8, pready held 0 -> psel/penable drop after 8 ACCESS cycles, rvalid with rresp=10 and rdata=0.
- Reset asserted during ACCESS, plus rready held 0 in RESP for 4 cycles -> reset case returns to IDLE with all outputs 0 next cycle. Held-off case keeps rvalid/rdata stable and arready 0.
